path_delay_sched: RTL and testbench



---
 rtl/path_delay_pkg.sv | 29 ++
 rtl/path_delay_sched_if.sv | 41 ++++
 rtl/path_delay_sel.sv | 54 +++++
 rtl/path_delay_sched.sv | 131 +++++++++++++
 tb/tb_path_delay_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/path_delay_pkg.sv
// ----------------------------------------------------------------------------
// path_delay_pkg
// Shared types for the path_delay_sched block.
//   level_t  : output level of the driven path (0, 1, high-Z)
//   state_t  : scheduler state (IDLE / PEND)
//   to_level : maps a requested (value, output-enable) pair onto a level_t
// Optional feature macro used by the block: PATH_DELAY_GLITCH_CNT_EN
// ----------------------------------------------------------------------------
package path_delay_pkg;

    typedef enum logic [1:0] {
        L0 = 2'b00,
        L1 = 2'b01,
        LZ = 2'b10
    } level_t;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    function automatic level_t to_level(input logic val, input logic oe);
        if (!oe) begin
            return LZ;
        end
        return val ? L1 : L0;
    endfunction

endpackage

// File: rtl/path_delay_sched_if.sv
// ----------------------------------------------------------------------------
// path_delay_sched_if
// Groups the request side (c_val, c_oe) and the driven side (q_val, q_oe,
// busy) of the path delay scheduler.
//   master : stimulus / upstream logic, drives c_val and c_oe
//   slave  : path_delay_sched, drives q_val, q_oe, busy
// With PATH_DELAY_GLITCH_CNT_EN defined, the slave also drives glitch_cnt[15:0].
// ----------------------------------------------------------------------------
interface path_delay_sched_if;

    logic c_val;
    logic c_oe;
    logic q_val;
    logic q_oe;
    logic busy;

`ifdef PATH_DELAY_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;

    modport master (
        output c_val, c_oe,
        input  q_val, q_oe, busy, glitch_cnt
    );

    modport slave (
        input  c_val, c_oe,
        output q_val, q_oe, busy, glitch_cnt
    );
`else
    modport master (
        output c_val, c_oe,
        input  q_val, q_oe, busy
    );

    modport slave (
        input  c_val, c_oe,
        output q_val, q_oe, busy
    );
`endif

endinterface

// File: rtl/path_delay_sel.sv
// ----------------------------------------------------------------------------
// path_delay_sel
// Combinational delay lookup for a transition between two output levels.
// Ports:
//   from_lvl [level_t] in  : current output level
//   to_lvl   [level_t] in  : requested output level
//   delay    [DW-1:0]  out : transition delay in cycles (0 when from == to)
// Parameters: DW plus the six per-transition delays T01..TZ0.
// ----------------------------------------------------------------------------
module path_delay_sel
    import path_delay_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned T01 = 12,
    parameter int unsigned T10 = 16,
    parameter int unsigned T0Z = 13,
    parameter int unsigned TZ1 = 10,
    parameter int unsigned T1Z = 14,
    parameter int unsigned TZ0 = 34
) (
    input  level_t          from_lvl,
    input  level_t          to_lvl,
    output logic [DW-1:0]   delay
);

    always_comb begin
        delay = '0;
        case (from_lvl)
            L0: begin
                case (to_lvl)
                    L1:      delay = DW'(T01);
                    LZ:      delay = DW'(T0Z);
                    default: delay = '0;
                endcase
            end
            L1: begin
                case (to_lvl)
                    L0:      delay = DW'(T10);
                    LZ:      delay = DW'(T1Z);
                    default: delay = '0;
                endcase
            end
            LZ: begin
                case (to_lvl)
                    L0:      delay = DW'(TZ0);
                    L1:      delay = DW'(TZ1);
                    default: delay = '0;
                endcase
            end
            default: delay = '0;
        endcase
    end

endmodule

// File: rtl/path_delay_sched.sv
// ----------------------------------------------------------------------------
// path_delay_sched
// Cycle-based driver for a C->Q module path with transition-dependent,
// inertial (pulse-rejecting) delays over the levels 0, 1 and Z.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-high reset
//   bus  slave modport of path_delay_sched_if:
//     c_val, c_oe in  : requested value / output enable (c_oe=0 requests Z)
//     q_val       out : current value, 0 whenever q_oe=0
//     q_oe        out : current output enable (0 = Z)
//     busy        out : a transition is pending
//     glitch_cnt  out : [15:0] saturating count of cancelled transitions,
//                       present only with PATH_DELAY_GLITCH_CNT_EN defined
// ----------------------------------------------------------------------------
module path_delay_sched
    import path_delay_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned T01 = 12,
    parameter int unsigned T10 = 16,
    parameter int unsigned T0Z = 13,
    parameter int unsigned TZ1 = 10,
    parameter int unsigned T1Z = 14,
    parameter int unsigned TZ0 = 34
) (
    input  logic               clk,
    input  logic               rst,
    path_delay_sched_if.slave  bus
);

    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    level_t          target;
    level_t          q_level;
    level_t          pend_target;
    state_t          state;
    logic [DW-1:0]   cnt;
    logic [DW-1:0]   dly;

    assign target = to_level(bus.c_val, bus.c_oe);

    // Delay is always measured from the level actually being driven, so a
    // single lookup serves both the initial schedule and a retarget.
    path_delay_sel #(
        .DW  (DW),
        .T01 (T01),
        .T10 (T10),
        .T0Z (T0Z),
        .TZ1 (TZ1),
        .T1Z (T1Z),
        .TZ0 (TZ0)
    ) u_sel (
        .from_lvl (q_level),
        .to_lvl   (target),
        .delay    (dly)
    );

`ifdef PATH_DELAY_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
    assign bus.glitch_cnt = glitch_cnt;
`endif

    // cnt holds the number of PEND edges still to go; the edge seeing cnt==1
    // is edge k+D, where the pending level is applied. Maturity takes
    // priority over any new request arriving on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_level     <= LZ;
            pend_target <= LZ;
            state       <= IDLE;
            cnt         <= '0;
`ifdef PATH_DELAY_GLITCH_CNT_EN
            glitch_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (target != q_level) begin
                        pend_target <= target;
                        if (dly == '0) begin
                            q_level <= target;
                        end else begin
                            state <= PEND;
                            cnt   <= dly;
                        end
                    end
                end
                PEND: begin
                    if (cnt <= CNT_ONE) begin
                        q_level <= pend_target;
                        state   <= IDLE;
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end else if (target == pend_target) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (target == q_level) begin
                        // Request fell back to the driven level: pulse rejected.
                        state <= IDLE;
                        cnt   <= '0;
`ifdef PATH_DELAY_GLITCH_CNT_EN
                        if (glitch_cnt != 16'hFFFF) begin
                            glitch_cnt <= glitch_cnt + 16'd1;
                        end
`endif
                    end else begin
                        // Third level requested: restart timing from this edge.
                        pend_target <= target;
                        if (dly == '0) begin
                            q_level <= target;
                            state   <= IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= dly;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy  = (state == PEND);
    assign bus.q_oe  = (q_level != LZ);
    assign bus.q_val = (q_level == L1);

endmodule

// File: tb/tb_path_delay_sched.sv
// ----------------------------------------------------------------------------
// tb_path_delay_sched
// Self-checking bench for path_delay_sched. Two instances share the same
// request stimulus: u_dut0 with default delays, u_dut1 with T01=0.
// Both are compared every cycle against a reference model that tracks the
// output level, the pending level and the absolute edge at which it is due.
// Honours PATH_DELAY_GLITCH_CNT_EN for the glitch counter output.
// ----------------------------------------------------------------------------
module tb_path_delay_sched;

    logic clk;
    logic rst;
    logic c_val;
    logic c_oe;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    path_delay_sched_if bus0 ();
    path_delay_sched_if bus1 ();

    assign bus0.c_val = c_val;
    assign bus0.c_oe  = c_oe;
    assign bus1.c_val = c_val;
    assign bus1.c_oe  = c_oe;

    path_delay_sched u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    path_delay_sched #(
        .T01 (0)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: levels 0, 1, 2(=Z); one entry per instance.
    int          m_lvl  [2];
    bit          m_pend [2];
    int          m_tgt  [2];
    int unsigned m_due  [2];
    int unsigned m_gl   [2];
    int unsigned edge_no = 0;

    function automatic int unsigned dly_of(int inst, int f, int t);
        if (f == 0 && t == 1) return (inst == 1) ? 0 : 12;
        if (f == 1 && t == 0) return 16;
        if (f == 0 && t == 2) return 13;
        if (f == 2 && t == 1) return 10;
        if (f == 1 && t == 2) return 14;
        if (f == 2 && t == 0) return 34;
        return 0;
    endfunction

    task automatic schedule(int inst, int tgt);
        int unsigned d;
        d = dly_of(inst, m_lvl[inst], tgt);
        if (d == 0) begin
            m_lvl[inst]  = tgt;
            m_pend[inst] = 1'b0;
        end else begin
            m_pend[inst] = 1'b1;
            m_tgt[inst]  = tgt;
            m_due[inst]  = edge_no + d;
        end
    endtask

    task automatic model_edge(int inst, int tgt, bit r);
        if (r) begin
            m_lvl[inst]  = 2;
            m_pend[inst] = 1'b0;
            m_gl[inst]   = 0;
        end else if (m_pend[inst]) begin
            if (edge_no == m_due[inst]) begin
                m_lvl[inst]  = m_tgt[inst];
                m_pend[inst] = 1'b0;
            end else if (tgt == m_tgt[inst]) begin
                // keep waiting
            end else if (tgt == m_lvl[inst]) begin
                m_pend[inst] = 1'b0;
                if (m_gl[inst] < 16'hFFFF) m_gl[inst] = m_gl[inst] + 1;
            end else begin
                schedule(inst, tgt);
            end
        end else if (tgt != m_lvl[inst]) begin
            schedule(inst, tgt);
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: model consumes the inputs the DUTs sampled, then all
    // outputs are compared 1 time unit after the edge.
    task automatic step();
        int tgt;
        tgt = c_oe ? (c_val ? 1 : 0) : 2;
        @(posedge clk);
        model_edge(0, tgt, rst);
        model_edge(1, tgt, rst);
        edge_no++;
        #1;
        chk("d0_q_oe",  16'(bus0.q_oe),  16'(m_lvl[0] != 2));
        chk("d0_q_val", 16'(bus0.q_val), 16'(m_lvl[0] == 1));
        chk("d0_busy",  16'(bus0.busy),  16'(m_pend[0]));
        chk("d1_q_oe",  16'(bus1.q_oe),  16'(m_lvl[1] != 2));
        chk("d1_q_val", 16'(bus1.q_val), 16'(m_lvl[1] == 1));
        chk("d1_busy",  16'(bus1.busy),  16'(m_pend[1]));
`ifdef PATH_DELAY_GLITCH_CNT_EN
        chk("d0_glitch", bus0.glitch_cnt, 16'(m_gl[0]));
        chk("d1_glitch", bus1.glitch_cnt, 16'(m_gl[1]));
`endif
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 2; m_pend[i] = 1'b0; m_tgt[i] = 2; m_due[i] = 0; m_gl[i] = 0;
        end
        rst   = 1'b1;
        c_val = 1'b0;
        c_oe  = 1'b0;

        // Reset state
        steps(2);
        chk("rst_q_oe",  16'(bus0.q_oe),  16'd0);
        chk("rst_q_val", 16'(bus0.q_val), 16'd0);
        chk("rst_busy",  16'(bus0.busy),  16'd0);
        rst = 1'b0;

        // Z -> 1 takes TZ1 = 10 edges
        c_oe = 1'b1; c_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("tz1_hold_oe", 16'(bus0.q_oe), 16'd0);
            chk("tz1_busy",    16'(bus0.busy), 16'd1);
        end
        step();
        chk("tz1_q_oe",  16'(bus0.q_oe),  16'd1);
        chk("tz1_q_val", 16'(bus0.q_val), 16'd1);
        chk("tz1_idle",  16'(bus0.busy),  16'd0);

        // 1 -> 0 takes T10 = 16 edges
        c_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t10_hold", 16'(bus0.q_val), 16'd1);
        end
        step();
        chk("t10_q_val", 16'(bus0.q_val), 16'd0);
        chk("t10_idle",  16'(bus0.busy),  16'd0);

        // 5-cycle pulse on c_val from steady 0 is rejected
        c_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("glitch_busy", 16'(bus0.busy),  16'd1);
            chk("glitch_hold", 16'(bus0.q_val), 16'd0);
        end
        c_val = 1'b0;
        step();
        chk("cancel_busy",  16'(bus0.busy),  16'd0);
        chk("cancel_q_val", 16'(bus0.q_val), 16'd0);
`ifdef PATH_DELAY_GLITCH_CNT_EN
        chk("cancel_cnt", bus0.glitch_cnt, 16'd1);
`endif
        steps(40);

        // Retarget 1 -> (0) -> Z at edge 3: Z appears at 3 + T1Z = 17
        c_val = 1'b1;
        steps(40);
        c_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rt_hold_val", 16'(bus0.q_val), 16'd1);
        end
        c_oe = 1'b0;
        for (int i = 3; i <= 16; i++) begin
            step();
            chk("rt_hold_oe",  16'(bus0.q_oe),  16'd1);
            chk("rt_hold_val", 16'(bus0.q_val), 16'd1);
        end
        step();
        chk("rt_q_oe", 16'(bus0.q_oe), 16'd0);
        chk("rt_idle", 16'(bus0.busy), 16'd0);

        // Reset in the middle of a pending Z -> 1
        c_oe = 1'b1; c_val = 1'b1;
        steps(5);
        rst = 1'b1;
        step();
        chk("mrst_q_oe", 16'(bus0.q_oe), 16'd0);
        chk("mrst_busy", 16'(bus0.busy), 16'd0);
        rst = 1'b0;
        steps(5);
        chk("mrst_e10_q_oe", 16'(bus0.q_oe), 16'd0);

        // T01 = 0 instance: 0 -> 1 on the sampling edge, never busy
        c_val = 1'b0;
        steps(50);
        c_val = 1'b1;
        step();
        chk("t01z_q_val", 16'(bus1.q_val), 16'd1);
        chk("t01z_busy",  16'(bus1.busy),  16'd0);
        chk("t01z_d0_busy", 16'(bus0.busy), 16'd1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t01z_never_busy", 16'(bus1.busy), 16'd0);
        end

        // Randomized requests with variable hold times and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                c_val = 1'($urandom_range(0, 1));
                c_oe  = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        steps(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
